// File: rtl/ro_freq_meter.sv
// Purpose : ring-oscillator frequency meter; counts synchronized osc_in rising edges over a fixed clk window.
// Latency : result (count/ovf/done) appears 1 cycle after the last window cycle; SETTLE_CYCLES+GATE_CYCLES after start.
// Backpressure: none; start is ignored while busy or disabled, done is a single-cycle pulse with no handshake.
//
// Ports:
//   clk     system clock, all state on its rising edge
//   rst_n   asynchronous active-low reset
//   en      block enable; low aborts any measurement and holds the FSM idle
//   start   single-cycle measurement request
//   osc_in  asynchronous oscillator output under measurement
//   osc_en  enable to the ring oscillator (high in SETTLE and GATE)
//   busy    same as osc_en
//   done    one-cycle pulse when count/ovf are updated
//   count   edges counted in the last completed window
//   ovf     overflow flag for the last completed window
//
// Build option: define RO_METER_SAT_EN to make the edge counter saturate instead of wrap.
module ro_freq_meter #(
    parameter int CNT_W         = 16,
    parameter int GATE_CYCLES   = 1000,
    parameter int SETTLE_CYCLES = 15,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic             osc_in,
    output logic             osc_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] GATE   = 2'd2;

    localparam int TMAX  = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [1:0]             state;
    logic [TMR_W-1:0]       timer;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   edge_pulse;
    logic [CNT_W-1:0]       edge_cnt;
    logic [CNT_W-1:0]       edge_cnt_nxt;
    logic                   ovf_acc;
    logic                   ovf_acc_nxt;

    // Synchronizer runs continuously and is only cleared by reset. Keeping its
    // history across measurements means a level that was already high when a
    // window opens is never mistaken for a fresh rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], osc_in};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~sync_prev;

    // Next edge-counter value if this is a counting cycle.
    always_comb begin
        edge_cnt_nxt = edge_cnt;
        ovf_acc_nxt  = ovf_acc;
        if (edge_pulse) begin
`ifdef RO_METER_SAT_EN
            // Pin at all-ones; any further edge marks the window as overflowed.
            if (&edge_cnt) begin
                ovf_acc_nxt = 1'b1;
            end else begin
                edge_cnt_nxt = edge_cnt + CNT_ONE;
            end
`else
            // All-ones before the increment means this edge wraps the counter.
            if (&edge_cnt) begin
                ovf_acc_nxt = 1'b1;
            end
            edge_cnt_nxt = edge_cnt + CNT_ONE;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            edge_cnt <= '0;
            ovf_acc  <= 1'b0;
            count    <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && start) begin
                        state    <= SETTLE;
                        timer    <= SETTLE_LOAD;
                        edge_cnt <= '0;
                        ovf_acc  <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (timer == '0) begin
                        state <= GATE;
                        timer <= GATE_LOAD;
                    end else begin
                        timer <= timer - TMR_ONE;
                    end
                end
                GATE: begin
                    if (!en) begin
                        // Abort: published result is left untouched.
                        state <= IDLE;
                    end else begin
                        edge_cnt <= edge_cnt_nxt;
                        ovf_acc  <= ovf_acc_nxt;
                        if (timer == '0) begin
                            // Last window cycle: publish including this cycle's edge.
                            state <= IDLE;
                            count <= edge_cnt_nxt;
                            ovf   <= ovf_acc_nxt;
                            done  <= 1'b1;
                        end else begin
                            timer <= timer - TMR_ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign osc_en = (state != IDLE);
    assign busy   = osc_en;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: two instances (default parameters, and CNT_W=4 / GATE_CYCLES=100),
// an event-level reference model fed from sampled osc_in history, a per-cycle compare, and
// directed scenarios with hand-computed results.
module tb_ro_freq_meter;

    localparam int SETTLE = 15;
    localparam int SYNC   = 2;
    localparam int MAXC   = 16384;

    logic        clk;
    logic        rst_n;
    logic        en0, start0, osc0;
    logic        osc_en0, busy0, done0, ovf0;
    logic [15:0] count0;
    logic        en1, start1, osc1;
    logic        osc_en1, busy1, done1, ovf1;
    logic [3:0]  count1;

    int tests = 0;
    int fails = 0;

    ro_freq_meter dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en0),
        .start  (start0),
        .osc_in (osc0),
        .osc_en (osc_en0),
        .busy   (busy0),
        .done   (done0),
        .count  (count0),
        .ovf    (ovf0)
    );

    ro_freq_meter #(.CNT_W(4), .GATE_CYCLES(100)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en1),
        .start  (start1),
        .osc_in (osc1),
        .osc_en (osc_en1),
        .busy   (busy1),
        .done   (done1),
        .count  (count1),
        .ovf    (ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Square-wave generators: toggle every 'half' clk cycles, changing away from the rising edge.
    int half0 = 0;
    int half1 = 0;
    int ph0 = 0;
    int ph1 = 0;
    initial begin
        osc0 = 1'b0;
        forever begin
            @(negedge clk);
            if (half0 > 0) begin
                ph0++;
                if (ph0 >= half0) begin
                    ph0  = 0;
                    osc0 = ~osc0;
                end
            end
        end
    end
    initial begin
        osc1 = 1'b0;
        forever begin
            @(negedge clk);
            if (half1 > 0) begin
                ph1++;
                if (ph1 >= half1) begin
                    ph1  = 0;
                    osc1 = ~osc1;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // A measurement accepted at clock edge k keeps the oscillator enabled for
    // SETTLE+GATE cycles; edges seen during clock edges k+SETTLE+1 .. k+SETTLE+GATE
    // are counted, where the edge seen at clock edge m is a 0->1 step in the
    // osc_in samples taken SYNC+1 and SYNC edges earlier.
    int     cyc = 0;
    bit     hist [2][MAXC];
    bit     m_act  [2];
    int     m_k    [2];
    longint m_cnt  [2];
    bit     m_done [2];
    longint m_count[2];
    bit     m_ovf  [2];

    function automatic int gate_of(input int i);
        return (i == 0) ? 1000 : 100;
    endfunction

    function automatic int cw_of(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    function automatic bit hbit(input int i, input int j);
        if (j < 0) return 1'b0;
        return hist[i][j];
    endfunction

    task automatic model_step(input int i, input logic rstn, input logic e, input logic s,
                              input logic o, input int n);
        longint maxv;
        hist[i][n] = rstn ? o : 1'b0;
        m_done[i]  = 1'b0;
        if (!rstn) begin
            m_act[i]   = 1'b0;
            m_count[i] = 0;
            m_ovf[i]   = 1'b0;
        end else if (m_act[i]) begin
            if (!e) begin
                m_act[i] = 1'b0;
            end else begin
                if (n >= m_k[i] + SETTLE + 1 && hbit(i, n - SYNC) && !hbit(i, n - SYNC - 1))
                    m_cnt[i]++;
                if (n == m_k[i] + SETTLE + gate_of(i)) begin
                    m_act[i]  = 1'b0;
                    m_done[i] = 1'b1;
                    maxv      = (longint'(1) << cw_of(i)) - 1;
                    m_ovf[i]  = (m_cnt[i] > maxv);
`ifdef RO_METER_SAT_EN
                    m_count[i] = (m_cnt[i] > maxv) ? maxv : m_cnt[i];
`else
                    m_count[i] = m_cnt[i] % (maxv + 1);
`endif
                end
            end
        end else if (e && s) begin
            m_act[i] = 1'b1;
            m_k[i]   = n;
            m_cnt[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst_n, en0, start0, osc0, cyc);
        model_step(1, rst_n, en1, start1, osc1, cyc);
        if (cyc < MAXC - 1) cyc++;
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("osc_en0", 64'(osc_en0), 64'(m_act[0]));
        chk("busy0",   64'(busy0),   64'(m_act[0]));
        chk("done0",   64'(done0),   64'(m_done[0]));
        chk("count0",  64'(count0),  64'(m_count[0]));
        chk("ovf0",    64'(ovf0),    64'(m_ovf[0]));
        chk("osc_en1", 64'(osc_en1), 64'(m_act[1]));
        chk("busy1",   64'(busy1),   64'(m_act[1]));
        chk("done1",   64'(done1),   64'(m_done[1]));
        chk("count1",  64'(count1),  64'(m_count[1]));
        chk("ovf1",    64'(ovf1),    64'(m_ovf[1]));
    end

    // Pulse and busy-cycle counters, cleared by the stimulus between scenarios.
    int dcnt0 = 0;
    int dcnt1 = 0;
    int busycnt0 = 0;
    always @(negedge clk) begin
        if (done0 === 1'b1) dcnt0++;
        if (done1 === 1'b1) dcnt1++;
        if (busy0 === 1'b1) busycnt0++;
    end

    // Inputs change 1 time unit after the falling edge.
    task automatic cyc_wait(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int i, input int limit, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if ((i == 0 && done0 === 1'b1) || (i == 1 && done1 === 1'b1)) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    initial begin
        #(MAXC * 10);
        fails++;
        $display("FAIL watchdog: still running at t=%0t, limit %0d cycles", $time, MAXC);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bit ended;
        rst_n  = 1'b0;
        en0    = 1'b0;
        start0 = 1'b0;
        en1    = 1'b0;
        start1 = 1'b0;
        cyc_wait(3);
        chk("rst_busy0",  64'(busy0),  64'd0);
        chk("rst_count0", 64'(count0), 64'd0);
        rst_n = 1'b1;
        cyc_wait(2);

        // Disabled block ignores start.
        dcnt0 = 0;
        half0 = 2;
        cyc_wait(15);
        start0 = 1'b1;
        cyc_wait(1);
        start0 = 1'b0;
        cyc_wait(5);
        chk("dis_osc_en", 64'(osc_en0), 64'd0);
        chk("dis_done",   64'(dcnt0),   64'd0);
        chk("dis_count",  64'(count0),  64'd0);

        // Period 4: 1000-cycle window holds exactly 250 rising edges.
        en0 = 1'b1;
        cyc_wait(2);
        dcnt0    = 0;
        busycnt0 = 0;
        start0   = 1'b1;
        cyc_wait(1);
        start0 = 1'b0;
        wait_done(0, 1100, ok);
        chk("p4_done_seen", 64'(ok), 64'd1);
        cyc_wait(5);
        chk("p4_busy_cycles", 64'(busycnt0), 64'd1015);
        chk("p4_done_pulses", 64'(dcnt0),    64'd1);
        chk("p4_count",       64'(count0),   64'd250);
        chk("p4_ovf",         64'(ovf0),     64'd0);
        chk("p4_model_count", 64'(m_count[0]), 64'd250);

        // Period 10 with repeated start during busy: one result of 100 edges.
        half0 = 5;
        cyc_wait(3);
        dcnt0 = 0;
        ended = 1'b0;
        for (int c = 0; c < 1100; c++) begin
            start0 = (c % 7 == 0);
            cyc_wait(1);
            if (busy0 !== 1'b1) begin
                ended = 1'b1;
                break;
            end
        end
        chk("p10_window_end", 64'(ended),  64'd1);
        chk("p10_done_idle",  64'(done0),  64'd1);
        chk("p10_count",      64'(count0), 64'd100);
        // Start coinciding with done is accepted.
        start0 = 1'b1;
        cyc_wait(1);
        start0 = 1'b0;
        chk("start_on_done", 64'(busy0), 64'd1);

        // Abort that measurement about 500 cycles into the window.
        cyc_wait(514);
        en0 = 1'b0;
        cyc_wait(2);
        chk("abort_idle", 64'(busy0), 64'd0);
        en0 = 1'b1;
        cyc_wait(600);
        chk("abort_done_pulses", 64'(dcnt0),  64'd1);
        chk("abort_count_kept",  64'(count0), 64'd100);

        // Reset in the middle of the window.
        dcnt0  = 0;
        start0 = 1'b1;
        cyc_wait(1);
        start0 = 1'b0;
        cyc_wait(SETTLE + 300);
        chk("mid_busy", 64'(busy0), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_osc_en", 64'(osc_en0), 64'd0);
        chk("arst_busy",   64'(busy0),   64'd0);
        chk("arst_done",   64'(done0),   64'd0);
        chk("arst_count",  64'(count0),  64'd0);
        chk("arst_ovf",    64'(ovf0),    64'd0);
        cyc_wait(3);
        rst_n = 1'b1;
        cyc_wait(1100);
        chk("arst_no_done", 64'(dcnt0), 64'd0);
        chk("arst_idle",    64'(busy0), 64'd0);

        // Narrow counter: 50 edges into a 4-bit counter.
        en1   = 1'b1;
        half1 = 1;
        cyc_wait(4);
        dcnt1  = 0;
        start1 = 1'b1;
        cyc_wait(1);
        start1 = 1'b0;
        wait_done(1, 200, ok);
        chk("n4_done_seen", 64'(ok), 64'd1);
        cyc_wait(2);
        chk("n4_done_pulses", 64'(dcnt1), 64'd1);
        chk("n4_ovf",         64'(ovf1),  64'd1);
`ifdef RO_METER_SAT_EN
        chk("n4_count",       64'(count1),     64'd15);
        chk("n4_model_count", 64'(m_count[1]), 64'd15);
`else
        chk("n4_count",       64'(count1),     64'd2);
        chk("n4_model_count", 64'(m_count[1]), 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ro_freq_meter.md
RO_FREQ_METER -- requirements
Module: ro_freq_meter

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the edge counter and result.
REQ-002 Parameter GATE_CYCLES, default 1000, sets the clk cycles in the measurement window (>=1).
REQ-003 Parameter SETTLE_CYCLES, default 15, sets the clk cycles the oscillator runs before counting starts (>=1).
REQ-004 Parameter SYNC_STAGES, default 2, sets the flop stages synchronizing osc_in (>=2).
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  block enable; low forces IDLE and aborts any measurement.
REQ-008 start  input  1  single-cycle request to begin a measurement.
REQ-009 osc_in  input  1  asynchronous ring-oscillator output being measured.
REQ-010 osc_en  output  1  enable driven to the ring oscillator.
REQ-011 busy  output  1  high while in SETTLE or GATE.
REQ-012 done  output  1  one-cycle pulse when a result is valid.
REQ-013 count  output  CNT_W  rising edges of osc_in counted in the last completed window.
REQ-014 ovf  output  1  counter overflow flag for the last completed window.

Function
REQ-015 osc_in SHALL pass through SYNC_STAGES flops; a rising edge SHALL be detected as sync_out high with its previous value low, giving a one-cycle edge pulse.
REQ-016 The FSM SHALL have the states IDLE, SETTLE and GATE.
REQ-017 In IDLE, start=1 with en=1 SHALL move to SETTLE, clear the internal edge counter, and load the cycle timer with SETTLE_CYCLES-1.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then move to GATE with the timer loaded to GATE_CYCLES-1.
REQ-019 GATE SHALL last exactly GATE_CYCLES cycles and increment the edge counter on each cycle in which an edge pulse is present.
REQ-020 On the last GATE cycle the FSM SHALL return to IDLE. On the following cycle, count and ovf SHALL hold the final values and done SHALL be high for exactly one cycle.
REQ-021 osc_en SHALL be high in SETTLE and GATE and low in IDLE; busy SHALL equal osc_en.
REQ-022 start SHALL be ignored while busy=1 and while en=0.
REQ-023 en falling during SETTLE or GATE SHALL return the FSM to IDLE on the next edge, with no done pulse and count/ovf unchanged.
REQ-024 count and ovf SHALL hold their values until the next completed window.
REQ-025 start in the same cycle that done is high SHALL be accepted, because the FSM is already in IDLE.
REQ-026 The edge synchronizer history SHALL NOT be cleared at start, so that synchronizer latency never creates spurious edges.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, timer=0, edge counter=0, count=0, ovf=0, done=0, osc_en=0, busy=0 and all synchronizer flops to 0.
REQ-028 Reset asserted mid-measurement SHALL discard the measurement, and no done pulse SHALL follow reset release.

Configuration
REQ-029 With macro RO_METER_SAT_EN defined, the edge counter SHALL saturate at 2^CNT_W-1, and ovf SHALL be set if an edge arrives while the counter is saturated.
REQ-030 Without RO_METER_SAT_EN, the edge counter SHALL wrap modulo 2^CNT_W, ovf SHALL be set if any wrap occurred in the window, and the saturation logic SHALL NOT be present.

Verification
REQ-031 Apply reset, release it, hold en=0 for 15 cycles and pulse start -> osc_en, busy and done stay 0, and count=0.
REQ-032 Defaults, en=1, osc_in square wave of period 4 clk, pulse start -> osc_en high for 1015 cycles, a single done pulse, count=250 (+/-1), ovf=0.
REQ-033 Defaults, osc_in period 10 clk, start pulsed repeatedly during busy -> exactly one done pulse, count=100 (+/-1).
REQ-034 en dropped at cycle 500 of GATE -> FSM returns to IDLE, no done pulse, count keeps its prior value.
REQ-035 CNT_W=4, GATE_CYCLES=100, osc_in period 2 -> with RO_METER_SAT_EN, count=15 and ovf=1. Without it, count=50 mod 16=2 (+/-1) and ovf=1.
REQ-036 rst_n asserted mid-GATE -> all outputs 0 immediately, and no done pulse after release.
